// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: opcode values, instruction
// field positions and the issue FSM state encoding.
package alu_pkg;

    // Opcodes. 101 and 110 are unassigned; the ALU returns 0 for them.
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_MOVE = 3'b111;

    // Instruction layout: [7:5]=op, [4:3]=rd (also A source), [2:1]=rs, [0]=use_imm
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 1;
    localparam int IMM_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue unit.
// NREGS x DATA_W, two asynchronous operand read ports (a, b), one
// asynchronous debug read port, one synchronous write port, synchronous
// active-high reset clearing every register.
//  clk, rst          clock / synchronous reset
//  ra_addr/ra_data   operand A read
//  rb_addr/rb_data   operand B read
//  dbg_addr/dbg_data debug read
//  we, wa, wd        write enable / address / data
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [1:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [1:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [NREGS-1:0][DATA_W-1:0] rf;

    // Reset wins over a write in the same cycle, so an aborted EXEC leaves
    // the file cleared rather than partially updated.
    always_ff @(posedge clk) begin
        if (rst)
            rf <= '0;
        else if (we)
            rf[wa] <= wd;
    end

    assign ra_data  = rf[ra_addr];
    assign rb_data  = rf[rb_addr];
    assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Operand-fetch / issue / writeback stage around an external combinational
// 8-bit ALU. Accepts one instruction in IDLE, drives the ALU from the
// register file for one EXEC cycle, writes the result back and presents it
// on a valid/ready response until accepted.
//  clk, rst                   clock, synchronous active-high reset
//  in_valid/in_ready          instruction handshake (ready only in IDLE)
//  in_instr, in_imm           instruction word and immediate
//  alu_op/alu_a/alu_b         registered ALU drive
//  alu_result                 combinational ALU result
//  out_valid/out_ready        writeback handshake
//  out_data, out_rd           written value and its destination
//  dbg_addr/dbg_data          combinational register file peek
// Optional feature macro ALU_FLAGS_EN: adds flag_z / flag_n outputs,
// updated together with the register write.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_instr,
    input  logic [DATA_W-1:0] in_imm,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_rd,
`ifdef ALU_FLAGS_EN
    output logic              flag_z,
    output logic              flag_n,
`endif
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state, state_nx;
    logic [1:0]        rd_q;
    logic [DATA_W-1:0] ra_data, rb_data, wb;
    logic              accept, we;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign we       = (state == ST_EXEC);
    // MOVE bypasses the ALU: the B operand (imm or rf[rs]) is the result.
    assign wb       = (alu_op == OP_MOVE) ? alu_b : alu_result;

    alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (in_instr[RD_MSB:RD_LSB]),
        .ra_data  (ra_data),
        .rb_addr  (in_instr[RS_MSB:RS_LSB]),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (we),
        .wa       (rd_q),
        .wd       (wb)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept)    state_nx = ST_EXEC;
            ST_EXEC:                state_nx = ST_RESP;
            ST_RESP: if (out_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    // Operands are sampled in IDLE, before any write, so rd==rs reads the
    // old value. ALU drive registers hold their values outside EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rd_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rd    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    alu_op <= in_instr[OP_MSB:OP_LSB];
                    alu_a  <= ra_data;
                    alu_b  <= in_instr[IMM_BIT] ? in_imm : rb_data;
                    rd_q   <= in_instr[RD_MSB:RD_LSB];
                end
                ST_EXEC: begin
                    out_data  <= wb;
                    out_rd    <= rd_q;
                    out_valid <= 1'b1;
                end
                ST_RESP: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (we) begin
            flag_z <= (wb == '0);
            flag_n <= wb[DATA_W-1];
        end
    end
`endif

endmodule
